layer_sequencer: RTL

- Parametrised successor to the single-size layer controller. Runs a full forward pass over NUM_LAYERS layers on one shared bank of NUM_NEURON neurons.
- Each layer can use a different number of active neurons, set by the packed LAYER_SIZES parameter.
- Feeds each layer's collected outputs back as the next layer's inputs and supplies a per-layer weight base address to the weight memory.
- Adds a ready/valid start handshake, abort, a protocol-error flag and a one-cycle final-result strobe.

---
 rtl/layer_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/layer_sequencer.sv
// Forward-pass sequencer: steps one shared neuron bank through NUM_LAYERS layers of
// varying width, feeding each layer's collected results back as the next layer's inputs.
module layer_sequencer #(
    parameter int NUM_NEURON = 6,
    parameter int INPUT_SIZE = 9,
    parameter int NUM_LAYERS = 4,
    parameter int LSIZE_W    = 4,
    parameter logic [NUM_LAYERS*LSIZE_W-1:0] LAYER_SIZES = {4'd2, 4'd6, 4'd6, 4'd6},
    parameter int ADDR_SIZE  = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic                             start_ready,
    input  logic [NUM_NEURON*INPUT_SIZE-1:0] start_input,
    input  logic                             abort,
    input  logic [NUM_NEURON*INPUT_SIZE-1:0] layer_output,
    input  logic [NUM_NEURON-1:0]            layer_output_valid,
    output logic                             layer_start,
    output logic [NUM_NEURON-1:0]            active,
    output logic [NUM_NEURON*INPUT_SIZE-1:0] layer_input,
    output logic [$clog2(NUM_LAYERS):0]      layer_num,
    output logic [ADDR_SIZE-1:0]             weight_base,
    output logic [NUM_NEURON*INPUT_SIZE-1:0] final_output,
    output logic                             final_valid,
    output logic                             busy,
    output logic                             error
);

    localparam int LN_W   = $clog2(NUM_LAYERS) + 1;
    localparam int TBL_N  = 2 ** LN_W;
    localparam int LANE_W = NUM_NEURON * INPUT_SIZE;

    typedef logic [TBL_N-1:0][ADDR_SIZE-1:0]  base_tbl_t;
    typedef logic [TBL_N-1:0][NUM_NEURON-1:0] mask_tbl_t;

    // Tables are padded to the full layer_num range so indexing needs no width fixups.
    function automatic base_tbl_t build_bases();
        base_tbl_t            t;
        logic [ADDR_SIZE-1:0] acc;
        t   = '0;
        acc = '0;
        for (int l = 0; l < NUM_LAYERS; l++) begin
            t[l] = acc;
            acc  = acc + ADDR_SIZE'(LAYER_SIZES[l*LSIZE_W +: LSIZE_W]);
        end
        return t;
    endfunction

    function automatic mask_tbl_t build_masks();
        mask_tbl_t t;
        t = '0;
        for (int l = 0; l < NUM_LAYERS; l++)
            for (int i = 0; i < NUM_NEURON; i++)
                t[l][i] = (i < int'(LAYER_SIZES[l*LSIZE_W +: LSIZE_W]));
        return t;
    endfunction

    localparam base_tbl_t BASES = build_bases();
    localparam mask_tbl_t MASKS = build_masks();

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                state;
    logic [NUM_NEURON-1:0] collected;
    logic [LANE_W-1:0]     captured;

    logic [NUM_NEURON-1:0] hit;
    logic [LANE_W-1:0]     capture_next;
    logic [LANE_W-1:0]     capture_masked;
    logic                  complete;
    logic                  last_layer;
    logic                  stray_valid;
    logic [LN_W-1:0]       next_num;

    assign hit         = layer_output_valid & active;
    assign stray_valid = |(layer_output_valid & ~active);
    assign complete    = ((collected | hit) == active);
    assign last_layer  = (layer_num == LN_W'(NUM_LAYERS - 1));
    assign next_num    = layer_num + 1'b1;
    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);

    always_comb begin
        capture_next   = captured;
        capture_masked = '0;
        for (int i = 0; i < NUM_NEURON; i++) begin
            if (hit[i])
                capture_next[i*INPUT_SIZE +: INPUT_SIZE] = layer_output[i*INPUT_SIZE +: INPUT_SIZE];
            if (active[i])
                capture_masked[i*INPUT_SIZE +: INPUT_SIZE] = capture_next[i*INPUT_SIZE +: INPUT_SIZE];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            layer_start  <= 1'b0;
            active       <= '0;
            layer_input  <= '0;
            layer_num    <= '0;
            weight_base  <= '0;
            final_output <= '0;
            final_valid  <= 1'b0;
            error        <= 1'b0;
            collected    <= '0;
            captured     <= '0;
        end else begin
            layer_start <= 1'b0;
            final_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        layer_input <= start_input;
                        layer_num   <= '0;
                        weight_base <= '0;
                        error       <= 1'b0;
                        active      <= MASKS[0];
                        layer_start <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    collected <= '0;
                    if (abort) begin
                        active <= '0;
                        state  <= IDLE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    captured  <= capture_next;
                    collected <= collected | hit;
                    if (stray_valid)
                        error <= 1'b1;
                    // Abort wins over a completion landing in the same cycle.
                    if (abort) begin
                        active <= '0;
                        state  <= IDLE;
                    end else if (complete) begin
                        if (last_layer) begin
                            final_output <= capture_masked;
                            final_valid  <= 1'b1;
                            active       <= '0;
                            state        <= DONE;
                        end else begin
                            layer_input <= capture_masked;
                            layer_num   <= next_num;
                            weight_base <= BASES[next_num];
                            active      <= MASKS[next_num];
                            layer_start <= 1'b1;
                            state       <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    active <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
